// File: rtl/dram_sbox_lookup_sched.sv
// S-box lookup scheduler: arbitrates round-datapath and key-expansion lookups onto
// the shared 16-core DRAM read port, launches one parallel read and gathers the bytes.
module dram_sbox_lookup_sched #(
  parameter int unsigned TIMEOUT = 64,
  parameter logic        A_BANK  = 1'b0,
  parameter logic        K_BANK  = 1'b0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         A_REQ,
  input  logic [127:0] A_DIN,
  output logic         A_ACK,
  output logic [127:0] A_DOUT,
  input  logic         K_REQ,
  input  logic [31:0]  K_DIN,
  output logic         K_ACK,
  output logic [31:0]  K_DOUT,
  output logic [95:0]  RWL_ADD,
  output logic [47:0]  DEMUX_ADD,
  output logic         RD_START,
  input  logic [7:0]   RD_DATA,
  input  logic         RD_VLD,
  input  logic         RD_DONE,
  output logic         BUSY,
  output logic         ERR,
  output logic         GNT_K
);

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, RESP} state_t;

  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  state_t       state;
  logic         last_k;
  logic [4:0]   cnt;
  logic [9:0]   tmo;
  logic [127:0] data;

  logic         grant;
  logic         grant_k;
  logic [95:0]  rwl_next;
  logic [47:0]  demux_next;
  logic [4:0]   cnt_next;
  logic [127:0] data_next;

  // Addresses are formed straight from DIN so they can be registered at the grant edge.
  always_comb begin
    grant      = A_REQ | K_REQ;
    grant_k    = K_REQ & (~A_REQ | ~last_k);
    rwl_next   = '0;
    demux_next = '0;
    if (grant_k) begin
      for (int unsigned j = 0; j < 4; j++) begin
        rwl_next[6*(12+j) +: 6]   = K_DIN[8*j+2 +: 6];
        demux_next[3*(12+j) +: 3] = {K_BANK, K_DIN[8*j +: 2]};
      end
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        rwl_next[6*i +: 6]   = A_DIN[8*i+2 +: 6];
        demux_next[3*i +: 3] = {A_BANK, A_DIN[8*i +: 2]};
      end
    end
  end

  // Byte capture precedes the RD_DONE/timeout decision made from these values.
  always_comb begin
    cnt_next  = cnt;
    data_next = data;
    if (RD_VLD && !cnt[4]) begin
      data_next[{cnt[3:0], 3'b000} +: 8] = RD_DATA;
      cnt_next = cnt + 5'd1;
    end
  end

  assign BUSY = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      last_k    <= 1'b1;
      cnt       <= '0;
      tmo       <= '0;
      data      <= '0;
      A_ACK     <= 1'b0;
      K_ACK     <= 1'b0;
      A_DOUT    <= '0;
      K_DOUT    <= '0;
      RWL_ADD   <= '0;
      DEMUX_ADD <= '0;
      RD_START  <= 1'b0;
      ERR       <= 1'b0;
      GNT_K     <= 1'b0;
    end else begin
      A_ACK    <= 1'b0;
      K_ACK    <= 1'b0;
      RD_START <= 1'b0;
      ERR      <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            GNT_K     <= grant_k;
            last_k    <= grant_k;
            RWL_ADD   <= rwl_next;
            DEMUX_ADD <= demux_next;
            RD_START  <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          data  <= '0;
          cnt   <= '0;
          tmo   <= '0;
          state <= COLLECT;
        end
        COLLECT: begin
          data <= data_next;
          cnt  <= cnt_next;
          tmo  <= tmo + 10'd1;
          if (RD_DONE || tmo == TMO_LAST) begin
            state <= RESP;
            ERR   <= RD_DONE ? ~cnt_next[4] : 1'b1;
            if (GNT_K) begin
              K_ACK  <= 1'b1;
              K_DOUT <= data_next[127:96];
            end else begin
              A_ACK  <= 1'b1;
              A_DOUT <= data_next;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_sbox_lookup_sched.sv
// Directed bench for dram_sbox_lookup_sched: vector table of full transactions plus
// hand sequences for timeout, mid-read reset and round-robin arbitration.
`timescale 1ns/1ps
module tb_dram_sbox_lookup_sched;
  localparam int unsigned TIMEOUT = 64;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         A_REQ = 1'b0;
  logic [127:0] A_DIN = '0;
  logic         K_REQ = 1'b0;
  logic [31:0]  K_DIN = '0;
  logic [7:0]   RD_DATA = '0;
  logic         RD_VLD = 1'b0;
  logic         RD_DONE = 1'b0;
  logic         A_ACK, K_ACK, RD_START, BUSY, ERR, GNT_K;
  logic [127:0] A_DOUT;
  logic [31:0]  K_DOUT;
  logic [95:0]  RWL_ADD;
  logic [47:0]  DEMUX_ADD;

  int unsigned errors = 0;
  int unsigned checks = 0;
  string tag = "init";

  always #5 CLK = ~CLK;

  dram_sbox_lookup_sched #(.TIMEOUT(TIMEOUT), .A_BANK(1'b0), .K_BANK(1'b0)) dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_DIN(A_DIN), .A_ACK(A_ACK), .A_DOUT(A_DOUT),
    .K_REQ(K_REQ), .K_DIN(K_DIN), .K_ACK(K_ACK), .K_DOUT(K_DOUT),
    .RWL_ADD(RWL_ADD), .DEMUX_ADD(DEMUX_ADD), .RD_START(RD_START),
    .RD_DATA(RD_DATA), .RD_VLD(RD_VLD), .RD_DONE(RD_DONE),
    .BUSY(BUSY), .ERR(ERR), .GNT_K(GNT_K)
  );

  typedef struct {
    logic         is_k;
    logic [127:0] a_din;
    logic [31:0]  k_din;
    int unsigned  nvld;
    logic         done_sep;
    logic [127:0] rd_bytes;
    logic [95:0]  exp_rwl;
    logic [47:0]  exp_demux;
    logic [127:0] exp_a;
    logic [31:0]  exp_k;
    logic         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %b expected %b", tag, name, act, exp);
    end
  endtask

  // DRAM side: called at the ISSUE-cycle negedge; returns at the negedge of the RESP cycle.
  task automatic serve(input int unsigned nvld, input logic done_sep, input logic [127:0] rd_bytes);
    for (int unsigned k = 0; k < nvld; k++) begin
      @(negedge CLK);
      chk1("no_early_a_ack", A_ACK, 1'b0);
      chk1("no_early_k_ack", K_ACK, 1'b0);
      chk1("single_rd_start", RD_START, 1'b0);
      RD_VLD  = 1'b1;
      RD_DATA = (k < 16) ? rd_bytes[8*k +: 8] : 8'hEE;
      RD_DONE = !done_sep && (k == nvld - 1);
    end
    if (done_sep) begin
      @(negedge CLK);
      RD_VLD  = 1'b0;
      RD_DONE = 1'b1;
    end
    @(negedge CLK);
    RD_VLD  = 1'b0;
    RD_DONE = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    if (v.is_k) begin K_DIN = v.k_din; K_REQ = 1'b1; end
    else begin A_DIN = v.a_din; A_REQ = 1'b1; end
    @(negedge CLK);
    chk1("rd_start", RD_START, 1'b1);
    chk1("gnt_k", GNT_K, v.is_k);
    chk1("busy", BUSY, 1'b1);
    chk("rwl", 128'(RWL_ADD), 128'(v.exp_rwl));
    chk("demux", 128'(DEMUX_ADD), 128'(v.exp_demux));
    serve(v.nvld, v.done_sep, v.rd_bytes);
    chk1("a_ack", A_ACK, !v.is_k);
    chk1("k_ack", K_ACK, v.is_k);
    chk1("err", ERR, v.exp_err);
    chk("a_dout", A_DOUT, v.exp_a);
    chk("k_dout", 128'(K_DOUT), 128'(v.exp_k));
    chk("rwl_held", 128'(RWL_ADD), 128'(v.exp_rwl));
    A_REQ = 1'b0;
    K_REQ = 1'b0;
    @(negedge CLK);
    chk1("ack_pulse_end", A_ACK | K_ACK, 1'b0);
    chk1("err_clear", ERR, 1'b0);
    chk1("idle", BUSY, 1'b0);
  endtask

  initial begin
    vec_t v;
    int unsigned n;
    logic got;
    logic err_seen;

    vecs[0] = '{is_k: 1'b0, a_din: 128'h0F0E0D0C_0B0A0908_07060504_03020100, k_din: 32'h0,
                nvld: 16, done_sep: 1'b0, rd_bytes: 128'h6C6D6E6F_68696A6B_64656667_60616263,
                exp_rwl: 96'h0C30C3_082082_041041_000000, exp_demux: 48'h688688688688,
                exp_a: 128'h6C6D6E6F_68696A6B_64656667_60616263, exp_k: 32'h0, exp_err: 1'b0};
    vecs[1] = '{is_k: 1'b1, a_din: 128'h0, k_din: 32'hFFC08040,
                nvld: 16, done_sep: 1'b0, rd_bytes: 128'hDDCCBBAA_11111111_11111111_11111111,
                exp_rwl: 96'hFF0810_000000_000000_000000, exp_demux: 48'h600000000000,
                exp_a: 128'h6C6D6E6F_68696A6B_64656667_60616263, exp_k: 32'hDDCCBBAA, exp_err: 1'b0};
    vecs[2] = '{is_k: 1'b0, a_din: '1, k_din: 32'h0,
                nvld: 10, done_sep: 1'b0, rd_bytes: 128'h6C6D6E6F_68696A6B_64656667_60616263,
                exp_rwl: '1, exp_demux: 48'h6DB6DB6DB6DB,
                exp_a: 128'h00000000_00006A6B_64656667_60616263, exp_k: 32'hDDCCBBAA, exp_err: 1'b1};
    vecs[3] = '{is_k: 1'b0, a_din: 128'h0, k_din: 32'h0,
                nvld: 17, done_sep: 1'b1, rd_bytes: 128'h6C6D6E6F_68696A6B_64656667_60616263,
                exp_rwl: 96'h0, exp_demux: 48'h0,
                exp_a: 128'h6C6D6E6F_68696A6B_64656667_60616263, exp_k: 32'hDDCCBBAA, exp_err: 1'b0};
    vecs[4] = '{is_k: 1'b1, a_din: 128'h0, k_din: 32'h0,
                nvld: 16, done_sep: 1'b1, rd_bytes: 128'h04030201_11111111_11111111_11111111,
                exp_rwl: 96'h0, exp_demux: 48'h0,
                exp_a: 128'h6C6D6E6F_68696A6B_64656667_60616263, exp_k: 32'h04030201, exp_err: 1'b0};
    vecs[5] = '{is_k: 1'b1, a_din: 128'h0, k_din: 32'h03020100,
                nvld: 13, done_sep: 1'b0, rd_bytes: 128'hDDCCBBAA_11111111_11111111_11111111,
                exp_rwl: 96'h0, exp_demux: 48'h688000000000,
                exp_a: 128'h6C6D6E6F_68696A6B_64656667_60616263, exp_k: 32'h000000AA, exp_err: 1'b1};

    // Reset state
    tag = "reset";
    @(negedge CLK);
    @(negedge CLK);
    chk1("a_ack", A_ACK, 1'b0);
    chk1("k_ack", K_ACK, 1'b0);
    chk1("rd_start", RD_START, 1'b0);
    chk1("busy", BUSY, 1'b0);
    chk1("err", ERR, 1'b0);
    chk1("gnt_k", GNT_K, 1'b0);
    chk("a_dout", A_DOUT, '0);
    chk("k_dout", 128'(K_DOUT), '0);
    chk("rwl", 128'(RWL_ADD), '0);
    chk("demux", 128'(DEMUX_ADD), '0);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      tag = $sformatf("vec%0d", i);
      run_txn(vecs[i]);
    end

    // No RD_DONE: abort after TIMEOUT collect cycles, then a normal lookup proceeds
    tag = "timeout";
    A_DIN = '0;
    A_REQ = 1'b1;
    @(negedge CLK);
    chk1("rd_start", RD_START, 1'b1);
    n = 0;
    got = 1'b0;
    err_seen = 1'b0;
    for (int unsigned i = 1; i <= TIMEOUT + 8 && !got; i++) begin
      @(negedge CLK);
      if (A_ACK) begin
        got = 1'b1;
        n = i - 1;
        err_seen = ERR;
      end
    end
    chk("edges_after_collect_entry", 128'(n), 128'(TIMEOUT));
    chk1("err", err_seen, 1'b1);
    chk("a_dout_empty", A_DOUT, '0);
    A_REQ = 1'b0;
    @(negedge CLK);
    chk1("busy_drop", BUSY, 1'b0);
    tag = "after_timeout";
    v = vecs[0];
    v.exp_k = 32'h000000AA;
    run_txn(v);

    // Reset during COLLECT, then stale completion while idle
    tag = "reset_mid";
    A_DIN = vecs[0].a_din;
    A_REQ = 1'b1;
    @(negedge CLK);
    A_REQ = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge CLK);
      RD_VLD = 1'b1;
      RD_DATA = 8'h5A;
    end
    @(negedge CLK);
    RD_VLD = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk1("a_ack", A_ACK, 1'b0);
    chk1("k_ack", K_ACK, 1'b0);
    chk1("busy", BUSY, 1'b0);
    chk1("rd_start", RD_START, 1'b0);
    chk1("err", ERR, 1'b0);
    chk("a_dout", A_DOUT, '0);
    chk("k_dout", 128'(K_DOUT), '0);
    chk("rwl", 128'(RWL_ADD), '0);
    RST = 1'b0;
    RD_VLD = 1'b1;
    RD_DATA = 8'h77;
    RD_DONE = 1'b1;
    @(negedge CLK);
    RD_VLD = 1'b0;
    RD_DONE = 1'b0;
    chk1("stale_no_ack", A_ACK | K_ACK, 1'b0);
    chk1("stale_idle", BUSY, 1'b0);
    @(negedge CLK);
    chk("stale_dout", A_DOUT, '0);
    tag = "after_reset";
    run_txn(vecs[0]);

    // Both requesters held from reset: grants alternate A, K, A, K
    tag = "rr";
    RST = 1'b1;
    A_DIN = vecs[0].a_din;
    K_DIN = vecs[1].k_din;
    A_REQ = 1'b1;
    K_REQ = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int unsigned t = 0; t < 4; t++) begin
      got = 1'b0;
      for (int unsigned i = 0; i < 6 && !got; i++) begin
        @(negedge CLK);
        if (RD_START) got = 1'b1;
      end
      chk1("start_seen", got, 1'b1);
      chk1("gnt_k", GNT_K, (t % 2) == 1);
      serve(16, 1'b0, vecs[1].rd_bytes);
      chk1("ack_a", A_ACK, (t % 2) == 0);
      chk1("ack_k", K_ACK, (t % 2) == 1);
    end
    A_REQ = 1'b0;
    K_REQ = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk1("rr_idle", BUSY, 1'b0);
    chk("rr_k_dout", 128'(K_DOUT), 128'(32'hDDCCBBAA));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
